// File: rtl/mbist_march_ctrl_if.sv
// Memory-under-test port bundle for the March C- BIST controller.
// Write data travels one cycle ahead of the address/command it belongs to.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  mem_write_read;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (output mem_write_read, mem_address, mem_wdata, input mem_rdata);
  modport slave  (input mem_write_read, mem_address, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: issues 10N ops back-to-back, checks reads
// two cycles later and keeps a mismatch count plus a first-failure record.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 2**ADDR_WIDTH-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pattern,
  mbist_march_ctrl_if.master    mem,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [15:0]           fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_rdata
);
  localparam int STAGES = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic [2:0] {IDLE, PREP, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
    logic [DATA_WIDTH-1:0] exp;
  } chk_t;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d, nxt_elem;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, nxt_addr;
  logic                  ph_q, ph_d, nxt_ph;
  logic                  drain_q, drain_d;
  logic [DATA_WIDTH-1:0] pat_q;
  logic                  two_op, down, elem_end, last_op, cur_wr, nxt_wr;
  logic [DATA_WIDTH-1:0] nxt_data, exp_data;
  logic                  clr, rd_vld, wr_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [STAGES:1]       vld_pipe;
  chk_t                  ent_pipe [STAGES:1];
  logic                  mismatch;

  // Successor of the current op: second half of a two-op element, next
  // address in the element's direction, or first op of the next element.
  always_comb begin
    two_op   = (elem_q != 3'd0) && (elem_q != 3'd5);
    down     = (elem_q == 3'd3) || (elem_q == 3'd4);
    elem_end = down ? (addr_q == '0) : (addr_q == LAST_A);
    last_op  = (elem_q == 3'd5) && elem_end;
    nxt_elem = elem_q;
    nxt_addr = addr_q;
    nxt_ph   = 1'b0;
    if (two_op && !ph_q) begin
      nxt_ph = 1'b1;
    end else if (elem_end) begin
      nxt_elem = elem_q + 3'd1;
      nxt_addr = ((nxt_elem == 3'd3) || (nxt_elem == 3'd4)) ? LAST_A : '0;
    end else begin
      nxt_addr = down ? addr_q - 1'b1 : addr_q + 1'b1;
    end
    cur_wr   = (elem_q == 3'd0) || ph_q;
    nxt_wr   = (nxt_elem == 3'd0) || nxt_ph;
    nxt_data = nxt_elem[0] ? ~pat_q : pat_q;
    exp_data = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~pat_q : pat_q;
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    drain_d = drain_q;
    clr     = 1'b0;
    rd_vld  = 1'b0;
    wr_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = PREP;
          clr     = 1'b1;
        end
      end
      PREP: begin
        wdata_o = pat_q;
        state_d = RUN;
        elem_d  = 3'd0;
        addr_d  = '0;
        ph_d    = 1'b0;
      end
      RUN: begin
        wr_o    = cur_wr;
        addr_o  = addr_q;
        rd_vld  = !cur_wr;
        wdata_o = nxt_wr ? nxt_data : '0;
        if (last_op) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          elem_d = nxt_elem;
          addr_d = nxt_addr;
          ph_d   = nxt_ph;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      drain_q <= drain_d;
    end
  end

  // Read check pipeline: memory returns data two cycles after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int s = 1; s <= STAGES; s++) ent_pipe[s] <= '0;
    end else begin
      vld_pipe[1] <= rd_vld;
      ent_pipe[1] <= '{addr: addr_q, elem: elem_q, exp: exp_data};
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        ent_pipe[s] <= ent_pipe[s-1];
      end
    end
  end

  assign mismatch = vld_pipe[STAGES] && (mem.mem_rdata != ent_pipe[STAGES].exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= '0;
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_rdata <= '0;
    end else if (clr) begin
      pat_q      <= pattern;
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_rdata <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
      if (!fail) begin
        fail_addr  <= ent_pipe[STAGES].addr;
        fail_elem  <= ent_pipe[STAGES].elem;
        fail_rdata <= mem.mem_rdata;
      end
    end
  end

  assign busy               = (state_q == PREP) || (state_q == RUN) || (state_q == DRAIN);
  assign done               = (state_q == DONE);
  assign mem.mem_write_read = wr_o;
  assign mem.mem_address    = addr_o;
  assign mem.mem_wdata      = wdata_o;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty-memory model plus a March C- reference
// built from the element table, directed spec cases and random runs.
module tb_mbist_march_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int N    = 16;
  localparam int NOPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, fail;
  logic [15:0]   fail_count;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_rdata;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif();

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .mem(mif),
    .busy(busy), .done(done), .fail(fail), .fail_count(fail_count),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_rdata(fail_rdata)
  );

  always #5 clk = ~clk;

  // Memory under test: write data registered one cycle ahead, two-cycle read
  // latency, stuck-at faults applied to the stored value.
  logic [DW-1:0] mem_arr [N];
  logic [DW-1:0] sa0 [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] wdata_q, rd1;

  always @(posedge clk) begin
    wdata_q <= mif.mem_wdata;
    if (mif.mem_write_read)
      mem_arr[mif.mem_address] <= (wdata_q & ~sa0[mif.mem_address]) | sa1[mif.mem_address];
    rd1           <= mem_arr[mif.mem_address];
    mif.mem_rdata <= rd1;
  end

  // March C- as a table: op count, direction, write flag, complement flag.
  int  E_NOP  [6]    = '{1, 2, 2, 2, 2, 1};
  bit  E_DOWN [6]    = '{0, 0, 0, 1, 1, 0};
  bit  E_WR   [6][2] = '{'{1,0}, '{0,1}, '{0,1}, '{0,1}, '{0,1}, '{0,0}};
  bit  E_INV  [6][2] = '{'{0,0}, '{0,1}, '{1,0}, '{0,1}, '{1,0}, '{0,0}};

  typedef struct {
    bit            wr;
    int            addr;
    logic [DW-1:0] d;
  } op_t;

  op_t           ops[$];
  logic [DW-1:0] rm [N];
  int            exp_cnt, exp_addr, exp_elem;
  logic [DW-1:0] exp_rdata;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_ref(input logic [DW-1:0] pat);
    op_t o;
    ops.delete();
    exp_cnt = 0; exp_addr = 0; exp_elem = 0; exp_rdata = '0;
    for (int m = 0; m < 6; m++)
      for (int j = 0; j < N; j++) begin
        int a;
        a = E_DOWN[m] ? N - 1 - j : j;
        for (int k = 0; k < E_NOP[m]; k++) begin
          o.wr = E_WR[m][k];
          o.addr = a;
          o.d = E_INV[m][k] ? ~pat : pat;
          ops.push_back(o);
          if (o.wr) rm[a] = (o.d & ~sa0[a]) | sa1[a];
          else if (rm[a] !== o.d) begin
            if (exp_cnt == 0) begin
              exp_addr = a; exp_elem = m; exp_rdata = rm[a];
            end
            exp_cnt++;
          end
        end
      end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  task automatic run_test(input logic [DW-1:0] pat, input bit poke);
    int op_err, wd_err, st_err;
    build_ref(pat);
    op_err = 0; wd_err = 0; st_err = 0;
    @(negedge clk); start = 1'b1; pattern = pat;
    @(negedge clk); start = 1'b0; pattern = DW'($urandom);
    chk("clr_status", {fail, fail_count, fail_addr, fail_elem, fail_rdata}, 32'h0);
    chk("busy_prep", {busy, done}, 32'h2);
    chk("prep_wdata", mif.mem_wdata, pat);
    for (int i = 0; i < NOPS; i++) begin
      @(negedge clk);
      start = poke && (i == 30);
      if (mif.mem_write_read !== ops[i].wr || mif.mem_address !== AW'(ops[i].addr)) op_err++;
      if (i + 1 < NOPS && ops[i+1].wr && mif.mem_wdata !== ops[i+1].d) wd_err++;
      if ({busy, done} !== 2'b10) st_err++;
    end
    start = 1'b0;
    chk("op_seq_errs", op_err, 0);
    chk("wdata_lead_errs", wd_err, 0);
    chk("busy_run_errs", st_err, 0);
    repeat (2) begin
      @(negedge clk);
      chk("drain", {busy, done, mif.mem_write_read, mif.mem_address, mif.mem_wdata}, 32'h4000);
    end
    @(negedge clk);
    chk("done_state", {busy, done, mif.mem_write_read, mif.mem_address, mif.mem_wdata}, 32'h2000);
    chk("fail", fail, exp_cnt != 0);
    chk("fail_count", fail_count, exp_cnt);
    chk("fail_addr", fail_addr, exp_addr);
    chk("fail_elem", fail_elem, exp_elem);
    chk("fail_rdata", fail_rdata, exp_rdata);
  endtask

  initial begin
    clear_faults();
    repeat (2) @(negedge clk);
    chk("reset_status", {busy, done, fail, fail_count, fail_addr, fail_elem}, 32'h0);
    chk("reset_bus", {fail_rdata, mif.mem_write_read, mif.mem_address, mif.mem_wdata}, 32'h0);
    rst_n = 1'b1;

    // fault-free, pattern 00
    run_test(8'h00, 1'b0);
    chk("r030_cnt", fail_count, 32'd0);

    // bit 0 of address 5 stuck at 0
    sa0[5] = 8'h01;
    run_test(8'h00, 1'b0);
    chk("r031_cnt", fail_count, 32'd2);
    chk("r031_addr", fail_addr, 32'd5);
    chk("r031_elem", fail_elem, 32'd2);
    chk("r031_rdata", fail_rdata, 32'hFE);
    clear_faults();

    run_test(8'h55, 1'b0);
    chk("r032_fail", fail, 32'd0);

    // asynchronous reset in the middle of RUN
    @(negedge clk); start = 1'b1; pattern = 8'h3C;
    @(negedge clk); start = 1'b0;
    repeat (51) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_status", {busy, done, fail, fail_count, fail_addr, fail_elem}, 32'h0);
    chk("async_rst_bus", {fail_rdata, mif.mem_write_read, mif.mem_address, mif.mem_wdata}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    run_test(8'h00, 1'b0);
    chk("r033_cnt", fail_count, 32'd0);

    // start pulsed during RUN is ignored; this run is also launched from DONE
    run_test(8'h00, 1'b1);

    // last address stuck at 1 on every bit
    sa1[N-1] = 8'hFF;
    run_test(8'h00, 1'b0);
    chk("r035_cnt", fail_count, 32'd3);
    chk("r035_addr", fail_addr, N - 1);
    chk("r035_elem", fail_elem, 32'd1);
    chk("r035_rdata", fail_rdata, 32'hFF);
    clear_faults();

    // randomized patterns and faults
    for (int r = 0; r < 6; r++) begin
      int fa;
      clear_faults();
      fa = $urandom_range(0, N - 1);
      if (r % 3 != 0) begin
        sa0[fa] = DW'($urandom) & DW'($urandom);
        sa1[fa] = DW'($urandom) & DW'($urandom) & DW'($urandom);
      end
      run_test(DW'($urandom), 1'b0);
    end
    clear_faults();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
